// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART APB sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG_SETUP,
        CFG_ACCESS,
        ARB,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [11:0] ADDR_DATA  = 12'h400;
    localparam logic [11:0] ADDR_STATE = 12'h404;
    localparam logic [11:0] ADDR_CTRL  = 12'h408;
    localparam logic [11:0] ADDR_BAUD  = 12'h410;

    // Index of the last configuration write (baud, ctrl, state).
    localparam logic [1:0]  CFG_LAST   = 2'd2;

    // Configuration order: divisor first so the line rate is valid before
    // the control register enables the UART.
    function automatic logic [11:0] cfg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_addr = ADDR_BAUD;
            2'd1:    cfg_addr = ADDR_CTRL;
            default: cfg_addr = ADDR_STATE;
        endcase
    endfunction

endpackage

// File: rtl/uart_seq_rr_arb.sv
// Round-robin arbiter over N_REQ byte requesters.
// Latency: grant is combinational; the pointer advances on the edge after accept_i.
// Backpressure: requests are held by the requesters; nothing is queued here.
// Ports: clk/rst (sync, active-high), req_i request vector, accept_i grant taken,
//        gnt_vld_o any request present, gnt_idx_o index of the granted requester.
module uart_seq_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    input  logic             accept_i,
    output logic             gnt_vld_o,
    output logic [IW-1:0]    gnt_idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Scan from the highest offset down so the requester closest to the
    // pointer is the one left standing.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % N_REQ]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        if (int'(gnt_idx_o) == N_REQ - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_apb_sequencer.sv
// APB master that configures the UART (0x410, 0x408, 0x404) and then serves
// N_REQ round-robin TX byte writes to 0x400 plus status reads of 0x404.
// Latency: 3 cycles minimum per transfer (ARB, SETUP, ACCESS); PREADY low
// stretches ACCESS. Backpressure: requesters hold req/data until their ack.
// Ports: cfg_* start and config bytes, cfg_done; tx_req/tx_data/tx_ack byte
// requesters; st_req/st_ack/st_data status read; PSEL..PREADY APB master;
// busy. Optional UART_SEQ_TIMEOUT_EN adds the err_timeout port and PREADY watchdog.
module uart_apb_sequencer
    import uart_seq_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               cfg_start,
    input  logic [7:0]         cfg_baud,
    input  logic [7:0]         cfg_ctrl,
    input  logic [7:0]         cfg_state,
    output logic               cfg_done,
    input  logic [N_REQ-1:0]   tx_req,
    input  logic [8*N_REQ-1:0] tx_data,
    output logic [N_REQ-1:0]   tx_ack,
    input  logic               st_req,
    output logic               st_ack,
    output logic [31:0]        st_data,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [11:0]        PADDR,
    output logic [7:0]         PWDATA,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
`ifdef UART_SEQ_TIMEOUT_EN
    output logic               err_timeout,
`endif
    output logic               busy
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 4 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("uart_apb_sequencer: N_REQ must be 2..4 and TIMEOUT_CYC >= 2");
    end

    state_t        state_q, state_d;
    logic [1:0]    cfg_idx_q;
    logic [7:0]    baud_q, ctrl_q, stv_q;
    logic          cfg_done_q;
    logic          is_rd_q;
    logic [IW-1:0] gnt_q;
    logic [7:0]    wdata_q;
    logic          st_ack_q;
    logic [31:0]   st_data_q;

    logic          arb_vld;
    logic [IW-1:0] arb_idx;
    logic          st_take, tx_take;
    logic          tmo_hit;

    // st_ack is registered, so the requester still holds st_req in the ARB
    // cycle that carries the ack; masking it there prevents a repeat read.
    assign st_take = (state_q == ARB) && st_req && !st_ack_q;
    assign tx_take = (state_q == ARB) && !st_take && arb_vld;

    uart_seq_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .clk       (PCLK),
        .rst       (PRESET),
        .req_i     (tx_req),
        .accept_i  (tx_take),
        .gnt_vld_o (arb_vld),
        .gnt_idx_o (arb_idx)
    );

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          err_timeout_q;
    logic          wait_acc;

    assign wait_acc = ((state_q == ACCESS) || (state_q == CFG_ACCESS)) && !PREADY;
    // Fires on the TIMEOUT_CYC-th consecutive ACCESS cycle without PREADY.
    assign tmo_hit  = wait_acc && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (wait_acc && !tmo_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end
            if (tmo_hit) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (cfg_start) state_d = CFG_SETUP;
            CFG_SETUP:  state_d = CFG_ACCESS;
            CFG_ACCESS: begin
                if (PREADY) begin
                    state_d = (cfg_idx_q == CFG_LAST) ? ARB : CFG_SETUP;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            ARB:        if (st_take || tx_take) state_d = SETUP;
            SETUP:      state_d = ACCESS;
            ACCESS:     if (PREADY || tmo_hit) state_d = ARB;
            default:    state_d = IDLE;
        endcase
    end

    // Datapath: config bytes, latched grant, read capture
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cfg_idx_q  <= '0;
            baud_q     <= '0;
            ctrl_q     <= '0;
            stv_q      <= '0;
            cfg_done_q <= 1'b0;
            is_rd_q    <= 1'b0;
            gnt_q      <= '0;
            wdata_q    <= '0;
            st_ack_q   <= 1'b0;
            st_data_q  <= '0;
        end else begin
            st_ack_q <= 1'b0;
            if (state_q == IDLE && cfg_start) begin
                cfg_idx_q <= '0;
                baud_q    <= cfg_baud;
                ctrl_q    <= cfg_ctrl;
                stv_q     <= cfg_state;
            end
            if (state_q == CFG_ACCESS && PREADY) begin
                cfg_idx_q <= cfg_idx_q + 2'd1;
                if (cfg_idx_q == CFG_LAST) begin
                    cfg_done_q <= 1'b1;
                end
            end
            if (st_take) begin
                is_rd_q <= 1'b1;
            end else if (tx_take) begin
                is_rd_q <= 1'b0;
                gnt_q   <= arb_idx;
                wdata_q <= tx_data[8*arb_idx +: 8];
            end
            if (state_q == ACCESS && PREADY && is_rd_q) begin
                st_ack_q  <= 1'b1;
                st_data_q <= PRDATA;
            end
        end
    end

    // Output logic
    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        tx_ack  = '0;
        busy    = !((state_q == IDLE) || (state_q == ARB));
        case (state_q)
            CFG_SETUP, CFG_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (state_q == CFG_ACCESS);
                PWRITE  = 1'b1;
                PADDR   = cfg_addr(cfg_idx_q);
                case (cfg_idx_q)
                    2'd0:    PWDATA = baud_q;
                    2'd1:    PWDATA = ctrl_q;
                    default: PWDATA = stv_q;
                endcase
            end
            SETUP, ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = (state_q == ACCESS);
                PWRITE  = !is_rd_q;
                PADDR   = is_rd_q ? ADDR_STATE : ADDR_DATA;
                PWDATA  = is_rd_q ? 8'h00 : wdata_q;
                if (state_q == ACCESS && PREADY && !is_rd_q) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        tx_ack[i] = (gnt_q == IW'(i));
                    end
                end
            end
            default: ;
        endcase
    end

    assign cfg_done = cfg_done_q;
    assign st_ack   = st_ack_q;
    assign st_data  = st_data_q;

endmodule

// File: doc/uart_apb_sequencer.md
Name: uart_apb_sequencer

Overview:
APB master that sequences the UART's APB slave port. After a start pulse it runs the configuration writes in order: baud register 0x410, then control 0x408, then state 0x404. It then round-robin arbitrates N_REQ byte-transmit requesters onto data register 0x400, plus one status-read requester. It sits between system-side producers and the UART APB slave and owns the PSEL/PENABLE/PWRITE/PADDR/PWDATA bus alone.

Parameters:
N_REQ, 2, number of TX byte requesters (2..4)
TIMEOUT_CYC, 1024, PREADY wait limit in PCLK cycles (used only with the optional feature)
ADDR_DATA, 12'h400, TX/RX data register
ADDR_STATE, 12'h404, state register
ADDR_CTRL, 12'h408, control register
ADDR_BAUD, 12'h410, baud/divisor register

Ports:
PCLK  in  1  sole clock
PRESET  in  1  synchronous, active-high reset
cfg_start  in  1  pulse: begin config sequence
cfg_baud  in  8  byte written to 0x410
cfg_ctrl  in  8  byte written to 0x408
cfg_state  in  8  byte written to 0x404
cfg_done  out  1  high once config has completed, until reset
tx_req  in  N_REQ  per-requester byte-valid
tx_data  in  8*N_REQ  packed bytes; requester i at [8i+7:8i]
tx_ack  out  N_REQ  one-cycle pulse when requester i's write completes
st_req  in  1  request a read of 0x404
st_ack  out  1  one-cycle pulse; st_data valid in the same cycle
st_data  out  32  captured PRDATA
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  12  APB address
PWDATA  out  8  APB write data
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
busy  out  1  high whenever FSM is not IDLE/ARB

Behaviour:
- Interface: single clock PCLK; PRESET is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, rr pointer 0, cfg_done 0.
- FSM states: IDLE, CFG_SETUP, CFG_ACCESS, ARB, SETUP, ACCESS.
- IDLE: waits for cfg_start. tx_req and st_req are ignored while cfg_done=0.
- Config sequence: a 2-bit cfg_idx counter steps through 0x410, 0x408, 0x404.
  - Each entry runs CFG_SETUP (PSEL=1, PENABLE=0, one cycle), then CFG_ACCESS (PSEL=1, PENABLE=1) until PREADY=1.
  - After the third PREADY: cfg_done=1, go to ARB.
  - cfg_start while not in IDLE is ignored.
- ARB: priority is st_req first, then the TX requesters in round-robin order starting at the rr pointer.
  - The grant is latched: address, write flag, data.
  - After a TX grant the rr pointer moves to (granted+1) mod N_REQ.
  - With nothing requested, stay in ARB with PSEL=0.
- SETUP then ACCESS follow APB rules. PADDR, PWRITE and PWDATA stay stable from SETUP through the PREADY cycle.
- Completion: on the ACCESS cycle where PREADY=1, the FSM pulses tx_ack[g] or st_ack and returns to ARB.
  - On a read completion, st_data<=PRDATA, and st_ack rises in the following cycle alongside the valid data.
  - Minimum transfer is 3 cycles (ARB, SETUP, ACCESS) with PREADY already high.
- Requesters must hold tx_req and tx_data until tx_ack. A requester that drops tx_req before its grant is skipped.
- PREADY sampled high during SETUP is ignored.
- Simultaneous st_req and tx_req: the status read wins. The rr pointer does not change.
- PRESET mid-transfer: PSEL and PENABLE drop to 0 on the next edge, no ack is issued, and cfg_done clears. Config must be re-run.

Optional Feature:
Macro UART_SEQ_TIMEOUT_EN.
- Defined:
  - A counter in CFG_ACCESS/ACCESS aborts the transfer after TIMEOUT_CYC cycles without PREADY.
  - On abort: bus released, sticky output err_timeout=1 (extra 1-bit port), no ack, FSM returns to ARB. If the timeout hits during config, the FSM returns to IDLE with cfg_done=0.
  - err_timeout clears only on PRESET.
- Undefined: the FSM waits indefinitely, and neither the port nor the counter exists.

Decomposition:
- Package uart_seq_pkg holds:
  - the state enum;
  - the address localparams;
  - the cfg-index-to-address function.
- One sub-module, uart_seq_rr_arb: an N_REQ round-robin arbiter, combinational grant plus registered pointer update on the accept strobe.

Test Plan:
- Config: cfg_start with baud=0x1B, ctrl=0x03, state=0x00, PREADY tied 1 -> writes to 0x410/0x408/0x404 with those PWDATA bytes, each SETUP 1 cycle and ACCESS 1 cycle; cfg_done rises after the third.
- Wait states: PREADY held low 5 cycles on the 0x400 write of 0xD8 -> PENABLE high for 6 cycles, PWDATA stays 0xD8, tx_ack[0] pulses once.
- Round-robin: tx_req=2'b11 continuously with bytes 0x48 (req0) and 0x45 (req1) -> write data alternates 0x48, 0x45, 0x48; acks alternate.
- Priority: st_req and tx_req[1] asserted together, PRDATA=0x0000_0005 -> read of 0x404 first, st_data=5 with st_ack, then the write to 0x400.
- Reset mid-ACCESS: PRESET pulsed while PREADY is low -> PSEL=0 next cycle, no ack, cfg_done=0, and tx_req is ignored until a new cfg_start.
- Timeout (with UART_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16): PREADY stuck low -> err_timeout=1 after 16 cycles, bus idle, next request still served.
